nn_train_feeder: RTL and testbench

Training-sample sequencer that drives the NN_CORE training port from the other side of the `update_coeff` / `finish_updating` handshake. It presents the four fixed XOR training samples on `input_k_1` and `input_k_2`, requests one coefficient update per sample, and waits for completion. It also scores the network outputs `a3_1` and `a3_2` against one-hot targets, then repeats for a programmed number of epochs. It replaces hand-written stimulus in front of NN_CORE and is the on-chip training controller.

---
 rtl/nn_train_feeder.sv | 167 ++++++++++++++++
 tb/tb_nn_train_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_train_feeder.sv
// On-chip XOR training sequencer for NN_CORE: steps through the four samples,
// handshakes one coefficient update per sample and scores the outputs per epoch.
module nn_train_feeder #(
   parameter int TIMEOUT = 4096,
   parameter int ERR_W   = 24
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    start,
   input  logic                    abort,
   input  logic [15:0]             epochs,
   input  logic                    finish_updating,
   input  logic signed [15:0]      a3_1,
   input  logic signed [15:0]      a3_2,
   output logic signed [15:0]      input_k_1,
   output logic signed [15:0]      input_k_2,
   output logic                    update_coeff,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic [1:0]              sample_idx,
   output logic [15:0]             epoch_count,
   output logic [ERR_W-1:0]        epoch_err,
   output logic                    epoch_err_valid
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int AW = ERR_W + 19;
   localparam logic [15:0] ONE = 16'h1000;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_CAPT, S_REL, S_FIN} state_t;

   state_t                r_state, w_next;
   logic [15:0]           r_epochs;
   logic [TW-1:0]         r_tcnt;
   logic signed [15:0]    r_a1, r_a2;
   logic [ERR_W-1:0]      r_acc;

   logic                  w_tmo, w_last;
   logic [15:0]           w_cnt_inc;
   logic [1:0]            w_idx_inc;
   logic [15:0]           w_t1, w_t2;
   logic signed [16:0]    w_d1, w_d2;
   logic [16:0]           w_ab1, w_ab2;
   logic [17:0]           w_err;
   logic [AW-1:0]         w_sum;
   logic [ERR_W-1:0]      w_acc_sat;

   assign w_tmo     = (r_tcnt == TW'(TIMEOUT - 1));
   assign w_last    = (sample_idx == 2'd3);
   assign w_cnt_inc = epoch_count + 16'd1;
   assign w_idx_inc = sample_idx + 2'd1;

   // XOR targets as one-hot: (1,0) when inputs are equal, (0,1) otherwise
   assign w_t1 = (sample_idx[1] == sample_idx[0]) ? ONE : 16'h0000;
   assign w_t2 = (sample_idx[1] != sample_idx[0]) ? ONE : 16'h0000;

   assign w_d1  = $signed({r_a1[15], r_a1}) - $signed({1'b0, w_t1});
   assign w_d2  = $signed({r_a2[15], r_a2}) - $signed({1'b0, w_t2});
   assign w_ab1 = w_d1[16] ? 17'(-w_d1) : 17'(w_d1);
   assign w_ab2 = w_d2[16] ? 17'(-w_d2) : 17'(w_d2);
   assign w_err = {1'b0, w_ab1} + {1'b0, w_ab2};

   // Sum is widened past both operands so the saturation compare never wraps
   assign w_sum     = AW'(r_acc) + AW'(w_err);
   assign w_acc_sat = (w_sum > AW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = (epochs == 16'd0) ? S_FIN : S_LOAD;
         S_LOAD: w_next = S_REQ;
         S_REQ: begin
            if (finish_updating)  w_next = S_CAPT;
            else if (w_tmo)       w_next = S_IDLE;
         end
         S_CAPT: w_next = S_REL;
         S_REL: begin
            if (!finish_updating) begin
               if (w_last && (w_cnt_inc == r_epochs)) w_next = S_FIN;
               else                                   w_next = S_LOAD;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_state         <= S_IDLE;
         busy            <= 1'b0;
         update_coeff    <= 1'b0;
         done            <= 1'b0;
         timeout         <= 1'b0;
         sample_idx      <= 2'd0;
         epoch_count     <= 16'd0;
         epoch_err       <= '0;
         epoch_err_valid <= 1'b0;
         input_k_1       <= 16'sd0;
         input_k_2       <= 16'sd0;
         r_epochs        <= 16'd0;
         r_tcnt          <= '0;
         r_a1            <= 16'sd0;
         r_a2            <= 16'sd0;
         r_acc           <= '0;
      end else begin
         r_state         <= w_next;
         busy            <= (w_next != S_IDLE);
         update_coeff    <= (w_next == S_REQ);
         done            <= (w_next == S_FIN);
         epoch_err_valid <= 1'b0;
         if (abort) begin
            r_acc <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_epochs    <= epochs;
                     timeout     <= 1'b0;
                     epoch_count <= 16'd0;
                     sample_idx  <= 2'd0;
                     r_acc       <= '0;
                     if (epochs != 16'd0) begin
                        input_k_1 <= 16'sd0;
                        input_k_2 <= 16'sd0;
                     end
                  end
               end
               S_LOAD: r_tcnt <= '0;
               S_REQ: begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (finish_updating) begin
                     r_a1 <= a3_1;
                     r_a2 <= a3_2;
                  end else if (w_tmo) begin
                     timeout <= 1'b1;
                  end
               end
               S_CAPT: r_acc <= w_acc_sat;
               S_REL: begin
                  if (!finish_updating) begin
                     if (!w_last) begin
                        sample_idx <= w_idx_inc;
                        input_k_1  <= w_idx_inc[1] ? ONE : 16'h0000;
                        input_k_2  <= w_idx_inc[0] ? ONE : 16'h0000;
                     end else begin
                        epoch_err       <= r_acc;
                        epoch_err_valid <= 1'b1;
                        r_acc           <= '0;
                        epoch_count     <= w_cnt_inc;
                        sample_idx      <= 2'd0;
                        if (w_cnt_inc != r_epochs) begin
                           input_k_1 <= 16'sd0;
                           input_k_2 <= 16'sd0;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nn_train_feeder.sv
// Scoreboarded bench: an NN_CORE responder feeds a3 values into a sum-based
// error model; a monitor checks sample requests and epoch results as they appear.
module tb_nn_train_feeder;

   localparam int TMO = 16;
   localparam int M_TGT = 0, M_HALF = 1, M_MIN = 2, M_RAND = 3, M_NEVER = 4;

   logic clk = 1'b0;
   logic res, start, abort, finish_updating;
   logic [15:0] epochs;
   logic signed [15:0] a3_1, a3_2;
   logic signed [15:0] input_k_1, input_k_2, s_k1, s_k2;
   logic update_coeff, busy, done, timeout, epoch_err_valid;
   logic s_uc, s_busy, s_done, s_tmo, s_vld;
   logic [1:0] sample_idx, s_idx;
   logic [15:0] epoch_count, s_cnt;
   logic [23:0] epoch_err;
   logic [11:0] s_err;

   typedef struct { logic [15:0] k1; logic [15:0] k2; logic [1:0] idx; } req_t;
   typedef struct { logic [23:0] e; logic [15:0] c; } ep_t;
   req_t q_req[$];
   ep_t  q_ep[$];
   logic [11:0] q_eps[$];

   int n_cmp = 0, n_err = 0, n_done = 0, n_rise = 0, uc_run = 0, last_len = 0;
   int mode = M_NEVER;
   int m_sum = 0, m_cnt = 0, m_ep = 0;
   logic uc_prev = 1'b0;

   always #5 clk = ~clk;

   nn_train_feeder #(.TIMEOUT(TMO), .ERR_W(24)) dut (
      .clk(clk), .res(res), .start(start), .abort(abort), .epochs(epochs),
      .finish_updating(finish_updating), .a3_1(a3_1), .a3_2(a3_2),
      .input_k_1(input_k_1), .input_k_2(input_k_2), .update_coeff(update_coeff),
      .busy(busy), .done(done), .timeout(timeout), .sample_idx(sample_idx),
      .epoch_count(epoch_count), .epoch_err(epoch_err), .epoch_err_valid(epoch_err_valid));

   nn_train_feeder #(.TIMEOUT(TMO), .ERR_W(12)) dut_s (
      .clk(clk), .res(res), .start(start), .abort(abort), .epochs(epochs),
      .finish_updating(finish_updating), .a3_1(a3_1), .a3_2(a3_2),
      .input_k_1(s_k1), .input_k_2(s_k2), .update_coeff(s_uc),
      .busy(s_busy), .done(s_done), .timeout(s_tmo), .sample_idx(s_idx),
      .epoch_count(s_cnt), .epoch_err(s_err), .epoch_err_valid(s_vld));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int tgt1(input int s);
      return (s == 0 || s == 3) ? 4096 : 0;
   endfunction

   // Reference: epoch error is the plain sum of |a-t| over four samples, clipped to the width
   task automatic record(input logic signed [15:0] a, input logic signed [15:0] b);
      int t1, t2, d1, d2;
      t1 = tgt1(m_cnt);
      t2 = 4096 - t1;
      d1 = int'(a) - t1; if (d1 < 0) d1 = -d1;
      d2 = int'(b) - t2; if (d2 < 0) d2 = -d2;
      m_sum += d1 + d2;
      m_cnt++;
      if (m_cnt == 4) begin
         m_ep++;
         q_ep.push_back('{e: 24'((m_sum > 24'hFFFFFF) ? 24'hFFFFFF : m_sum), c: 16'(m_ep)});
         q_eps.push_back(12'((m_sum > 4095) ? 4095 : m_sum));
         m_sum = 0;
         m_cnt = 0;
      end
   endtask

   task automatic push_reqs(input int E);
      for (int e = 0; e < E; e++)
         for (int s = 0; s < 4; s++)
            q_req.push_back('{k1: (s >= 2) ? 16'h1000 : 16'h0000,
                              k2: (s % 2 == 1) ? 16'h1000 : 16'h0000,
                              idx: 2'(s)});
   endtask

   // NN_CORE responder
   initial begin : resp
      int d, h;
      bit gone;
      logic signed [15:0] a, b;
      finish_updating = 1'b0;
      a3_1 = 16'sd0;
      a3_2 = 16'sd0;
      forever begin
         @(negedge clk);
         if (update_coeff === 1'b1 && mode != M_NEVER) begin
            d = (mode == M_TGT) ? 5 : int'($urandom_range(0, 7));
            h = (mode == M_TGT) ? 2 : int'($urandom_range(1, 3));
            gone = 1'b0;
            for (int i = 0; i < d; i++) begin
               @(negedge clk);
               if (update_coeff !== 1'b1) begin gone = 1'b1; break; end
            end
            if (!gone) begin
               case (mode)
                  M_TGT:   begin a = 16'(tgt1(m_cnt)); b = 16'(4096 - tgt1(m_cnt)); end
                  M_HALF:  begin a = 16'sh0800; b = 16'sh0800; end
                  M_MIN:   begin a = 16'sh8000; b = 16'sh8000; end
                  default: begin a = 16'($urandom); b = 16'($urandom); end
               endcase
               a3_1 = a;
               a3_2 = b;
               finish_updating = 1'b1;
               record(a, b);
               for (int i = 0; i < h; i++) @(negedge clk);
               finish_updating = 1'b0;
            end
         end
      end
   end

   // Monitor
   initial begin : mon
      req_t r;
      ep_t  e;
      logic [11:0] es;
      forever begin
         @(negedge clk);
         if (update_coeff === 1'b1 && !uc_prev) begin
            n_rise++;
            if (q_req.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL req_unexpected: got request idx %0d want none", sample_idx);
            end else begin
               r = q_req.pop_front();
               chk("req_k1", 32'(input_k_1), 32'(r.k1));
               chk("req_k2", 32'(input_k_2), 32'(r.k2));
               chk("req_idx", 32'(sample_idx), 32'(r.idx));
            end
         end
         uc_prev = (update_coeff === 1'b1);
         if (update_coeff === 1'b1) uc_run++;
         else if (uc_run != 0) begin last_len = uc_run; uc_run = 0; end
         if (epoch_err_valid === 1'b1) begin
            if (q_ep.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL ep_unexpected: got err %0h want no epoch", epoch_err);
            end else begin
               e = q_ep.pop_front();
               chk("ep_err", 32'(epoch_err), 32'(e.e));
               chk("ep_cnt", 32'(epoch_count), 32'(e.c));
            end
         end
         if (s_vld === 1'b1) begin
            if (q_eps.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL eps_unexpected: got err %0h want no epoch", s_err);
            end else begin
               es = q_eps.pop_front();
               chk("ep_err_sat", 32'(s_err), 32'(es));
            end
         end
         if (done === 1'b1) n_done++;
      end
   end

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL %s_idle: got busy after 5000 cycles want idle", nm);
      end
   endtask

   task automatic begin_run(input int E, input int md);
      mode = md; m_sum = 0; m_cnt = 0; m_ep = 0;
      push_reqs(E);
      epochs = 16'(E);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_tmo_clr", 32'(timeout), 32'd0);
      chk("start_uc_low", 32'(update_coeff), 32'd0);
   endtask

   task automatic run(input int E, input int md);
      int nd0;
      nd0 = n_done;
      begin_run(E, md);
      chk("start_k1", 32'(input_k_1), 32'd0);
      chk("start_k2", 32'(input_k_2), 32'd0);
      @(negedge clk);
      chk("req_rise", 32'(update_coeff), 32'd1);
      wait_idle("run");
      repeat (2) @(negedge clk);
      chk("run_done", 32'(n_done - nd0), 32'd1);
      chk("run_cnt", 32'(epoch_count), 32'(E));
      chk("run_req_left", 32'(q_req.size()), 32'd0);
      chk("run_ep_left", 32'(q_ep.size() + q_eps.size()), 32'd0);
   endtask

   initial begin : drv
      int nd0, nr0;
      bit ok;
      res = 1'b1; start = 1'b1; abort = 1'b0; epochs = 16'd5;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_uc", 32'(update_coeff), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);
      chk("rst_k", 32'({input_k_1, input_k_2}), 32'd0);
      chk("rst_idx_cnt", 32'({sample_idx, epoch_count}), 32'd0);
      chk("rst_err", 32'({epoch_err, epoch_err_valid}), 32'd0);
      res = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_start_ignored", 32'(busy), 32'd0);

      run(1, M_TGT);
      run(3, M_HALF);
      run(1, M_MIN);
      for (int i = 0; i < 4; i++) run(int'($urandom_range(1, 3)), M_RAND);

      // Timeout: responder never finishes
      nd0 = n_done;
      begin_run(2, M_NEVER);
      wait_idle("tmo");
      repeat (2) @(negedge clk);
      chk("tmo_uc_len", 32'(last_len), 32'(TMO));
      chk("tmo_flag", 32'(timeout), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_no_done", 32'(n_done - nd0), 32'd0);
      q_req.delete();

      // epochs = 0: one busy cycle with done, no request
      nd0 = n_done; nr0 = n_rise;
      epochs = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("e0_tmo_clr", 32'(timeout), 32'd0);
      chk("e0_busy", 32'(busy), 32'd1);
      chk("e0_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("e0_busy_end", 32'(busy), 32'd0);
      chk("e0_done_cnt", 32'(n_done - nd0), 32'd1);
      chk("e0_no_req", 32'(n_rise - nr0), 32'd0);

      // Abort during REQ of sample 2 in the second epoch
      nd0 = n_done;
      begin_run(3, M_TGT);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (update_coeff && sample_idx == 2'd2 && epoch_count == 16'd1) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL abort_wait: got no REQ of sample 2 want one within 2000 cycles");
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_uc", 32'(update_coeff), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cnt", 32'(epoch_count), 32'd1);
      repeat (4) @(negedge clk);
      chk("abort_stay_idle", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(n_done - nd0), 32'd0);
      q_req.delete();
      chk("abort_ep_left", 32'(q_ep.size() + q_eps.size()), 32'd0);

      // Fresh run after abort still scores from zero
      run(1, M_HALF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
